saes_decrypt_core: RTL and testbench



---
 rtl/saes_pkg.sv | 104 ++++++++++
 rtl/saes_key_expand.sv | 34 +++
 rtl/saes_decrypt_core.sv | 124 ++++++++++++
 tb/tb_saes_decrypt_core.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saes_pkg.sv
// saes_pkg: shared definitions for the S-AES decrypt core.
//   - FSM state encoding
//   - round constants for key expansion
//   - forward/inverse S-boxes and GF(2^4) arithmetic (x^4+x+1)
//   - inverse round functions: InvShiftRows, InvSubNib, InvMixColumns
// Nibble layout of a 16-bit state: S00=[15:12], S10=[11:8], S01=[7:4], S11=[3:0].
package saes_pkg;

   localparam logic [7:0] RCON1 = 8'h80;
   localparam logic [7:0] RCON2 = 8'h30;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      KEY  = 3'd1,
      R1   = 3'd2,
      R2   = 3'd3,
      R3   = 3'd4,
      DONE = 3'd5
   } state_t;

   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] r;
      r = 4'h0;
      case (n)
         4'h0: r = 4'h9;
         4'h1: r = 4'h4;
         4'h2: r = 4'hA;
         4'h3: r = 4'hB;
         4'h4: r = 4'hD;
         4'h5: r = 4'h1;
         4'h6: r = 4'h8;
         4'h7: r = 4'h5;
         4'h8: r = 4'h6;
         4'h9: r = 4'h2;
         4'hA: r = 4'h0;
         4'hB: r = 4'h3;
         4'hC: r = 4'hC;
         4'hD: r = 4'hE;
         4'hE: r = 4'hF;
         4'hF: r = 4'h7;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] n);
      logic [3:0] r;
      r = 4'h0;
      case (n)
         4'h0: r = 4'hA;
         4'h1: r = 4'h5;
         4'h2: r = 4'h9;
         4'h3: r = 4'hB;
         4'h4: r = 4'h1;
         4'h5: r = 4'h7;
         4'h6: r = 4'h8;
         4'h7: r = 4'hF;
         4'h8: r = 4'h6;
         4'h9: r = 4'h0;
         4'hA: r = 4'h2;
         4'hB: r = 4'h3;
         4'hC: r = 4'hC;
         4'hD: r = 4'h4;
         4'hE: r = 4'hD;
         4'hF: r = 4'hE;
      endcase
      return r;
   endfunction

   // Multiply by x: shift left, reduce by x^4+x+1 when bit 3 falls off.
   function automatic logic [3:0] gf16_mulx(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
   endfunction

   // Shift-and-add multiply; unrolls to a small XOR network.
   function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] acc;
      logic [3:0] p;
      acc = 4'h0;
      p   = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) acc = acc ^ p;
         p = gf16_mulx(p);
      end
      return acc;
   endfunction

   // Row 1 holds S10 and S11; swapping them undoes the shift.
   function automatic logic [15:0] inv_shift_rows(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   function automatic logic [15:0] inv_sub_nib(input logic [15:0] s);
      return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
   endfunction

   // Matrix [9 2; 2 9] applied to each column.
   function automatic logic [15:0] inv_mix_columns(input logic [15:0] s);
      return {gf16_mul(4'h9, s[15:12]) ^ gf16_mul(4'h2, s[11:8]),
              gf16_mul(4'h2, s[15:12]) ^ gf16_mul(4'h9, s[11:8]),
              gf16_mul(4'h9, s[7:4])   ^ gf16_mul(4'h2, s[3:0]),
              gf16_mul(4'h2, s[7:4])   ^ gf16_mul(4'h9, s[3:0])};
   endfunction

endpackage

// File: rtl/saes_key_expand.sv
// saes_key_expand: combinational S-AES key schedule.
// Ports:
//   key [15:0] in  - cipher key {w0, w1}
//   k0  [15:0] out - round key 0 {w0, w1}
//   k1  [15:0] out - round key 1 {w2, w3}
//   k2  [15:0] out - round key 2 {w4, w5}
module saes_key_expand
   import saes_pkg::*;
(
   input  logic [15:0] key,
   output logic [15:0] k0,
   output logic [15:0] k1,
   output logic [15:0] k2
);

   logic [7:0] w0, w1, w2, w3, w4, w5;

   // SubNib(RotNib(w)): rotate the nibbles, then substitute each.
   function automatic logic [7:0] sub_rot(input logic [7:0] w);
      return {sbox(w[3:0]), sbox(w[7:4])};
   endfunction

   assign w0 = key[15:8];
   assign w1 = key[7:0];
   assign w2 = w0 ^ RCON1 ^ sub_rot(w1);
   assign w3 = w2 ^ w1;
   assign w4 = w2 ^ RCON2 ^ sub_rot(w3);
   assign w5 = w4 ^ w3;

   assign k0 = {w0, w1};
   assign k1 = {w2, w3};
   assign k2 = {w4, w5};

endmodule

// File: rtl/saes_decrypt_core.sv
// saes_decrypt_core: iterative S-AES decryption engine.
// Ports:
//   clk             in  - clock, rising edge
//   rst_n           in  - asynchronous active-low reset
//   start           in  - request, accepted on a rising edge while ready=1
//   ciphertext[15:0] in - sampled on accept
//   key[15:0]       in  - sampled on accept
//   ready           out - high in IDLE and DONE
//   busy            out - high in KEY, R1, R2, R3
//   done            out - one-cycle pulse, plaintext valid
//   plaintext[15:0] out - result, held until the next done
//
// Handshake: a transfer happens on any rising edge where start=1 and ready=1.
// start while busy is dropped (no queueing). Inputs are only sampled on the
// transfer edge, so they may change freely afterwards. Because ready is also
// high in DONE, a new block can be accepted in the same cycle done pulses.
module saes_decrypt_core
   import saes_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] ciphertext,
   input  logic [15:0] key,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] plaintext
);

   state_t      state_q, state_d;
   logic        accept;
   logic [15:0] s_q;
   logic [15:0] key_q;
   logic [15:0] k0_q, k1_q, k2_q;
   logic [15:0] k0_w, k1_w, k2_w;

   saes_key_expand u_key_expand (
      .key (key_q),
      .k0  (k0_w),
      .k1  (k1_w),
      .k2  (k2_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = KEY;
            end
         end
         KEY: begin
            busy    = 1'b1;
            state_d = R1;
         end
         R1: begin
            busy    = 1'b1;
            state_d = R2;
         end
         R2: begin
            busy    = 1'b1;
            state_d = R3;
         end
         R3: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = KEY;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: the round keys are registered in KEY so the expansion logic
   // stays off the round paths. The last round writes straight into the
   // plaintext register, which therefore only moves on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q       <= 16'h0000;
         key_q     <= 16'h0000;
         k0_q      <= 16'h0000;
         k1_q      <= 16'h0000;
         k2_q      <= 16'h0000;
         plaintext <= 16'h0000;
      end else begin
         if (accept) begin
            s_q   <= ciphertext;
            key_q <= key;
         end
         case (state_q)
            KEY: begin
               k0_q <= k0_w;
               k1_q <= k1_w;
               k2_q <= k2_w;
            end
            R1:      s_q       <= inv_sub_nib(inv_shift_rows(s_q ^ k2_q));
            R2:      s_q       <= inv_mix_columns(s_q ^ k1_q);
            R3:      plaintext <= inv_sub_nib(inv_shift_rows(s_q)) ^ k0_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_saes_decrypt_core.sv
// tb_saes_decrypt_core: self-checking bench for saes_decrypt_core.
// Expected plaintexts are queued when a block is driven and compared when
// done pulses. Random round-trip vectors are produced by a local S-AES
// encryption model.
module tb_saes_decrypt_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] ciphertext;
   logic [15:0] key;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] plaintext;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_v;

   always #5 clk = ~clk;

   saes_decrypt_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ciphertext (ciphertext),
      .key        (key),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .plaintext  (plaintext)
   );

   // ---------------- encryption model ----------------
   localparam logic [3:0] SB [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                      4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

   function automatic logic [3:0] xtime(input logic [3:0] a);
      return a[3] ? ({a[2:0], 1'b0} ^ 4'h3) : {a[2:0], 1'b0};
   endfunction

   function automatic logic [15:0] sub16(input logic [15:0] s);
      return {SB[s[15:12]], SB[s[11:8]], SB[s[7:4]], SB[s[3:0]]};
   endfunction

   function automatic logic [15:0] shift16(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   function automatic logic [7:0] g8(input logic [7:0] w);
      return {SB[w[3:0]], SB[w[7:4]]};
   endfunction

   function automatic logic [15:0] encrypt(input logic [15:0] p, input logic [15:0] k);
      logic [7:0]  w0, w1, w2, w3, w4, w5;
      logic [15:0] s;
      logic [3:0]  n0, n1, n2, n3;
      w0 = k[15:8];
      w1 = k[7:0];
      w2 = w0 ^ 8'h80 ^ g8(w1);
      w3 = w2 ^ w1;
      w4 = w2 ^ 8'h30 ^ g8(w3);
      w5 = w4 ^ w3;
      s  = shift16(sub16(p ^ {w0, w1}));
      n0 = s[15:12];
      n1 = s[11:8];
      n2 = s[7:4];
      n3 = s[3:0];
      // MixColumns [1 4; 4 1]; 4*a = x*(x*a)
      s  = {n0 ^ xtime(xtime(n1)), xtime(xtime(n0)) ^ n1,
            n2 ^ xtime(xtime(n3)), xtime(xtime(n2)) ^ n3} ^ {w2, w3};
      s  = shift16(sub16(s)) ^ {w4, w5};
      return s;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         done_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: unexpected done, plaintext=%h, expected no done", plaintext);
         end else begin
            exp_v = exp_q.pop_front();
            if (plaintext !== exp_v) begin
               n_fail++;
               $display("FAIL scoreboard: plaintext=%h, expected %h", plaintext, exp_v);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Call right after a negedge: presents a block for the next rising edge.
   task automatic drive_block(input logic [15:0] ct, input logic [15:0] k, input logic [15:0] pt);
      start      = 1'b1;
      ciphertext = ct;
      key        = k;
      exp_q.push_back(pt);
   endtask

   // Counts negedges after a drive until done; drops start after the accept.
   // cyc = -1 when the bound expires.
   task automatic run_to_done(output int cyc);
      cyc = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done === 1'b1) begin
            cyc = c;
            return;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n      = 1'b0;
      start      = 1'b0;
      ciphertext = 16'h0000;
      key        = 16'h0000;
      repeat (2) @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", ready); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
      n_checks++;
      if (plaintext !== 16'h0000) begin n_fail++; $display("FAIL reset_plaintext: got %h, expected 0000", plaintext); end
      rst_n = 1'b1;
   endtask

   task automatic test_standard();
      int cyc;
      int ready_low;
      int busy_high;
      cyc       = -1;
      ready_low = 0;
      busy_high = 0;
      @(negedge clk);
      drive_block(16'h0738, 16'hA73B, 16'h6F6B);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done === 1'b1) begin
            cyc = c;
            break;
         end
         if (ready === 1'b0) ready_low++;
         if (busy === 1'b1) busy_high++;
      end
      n_checks++;
      if (cyc != 5) begin n_fail++; $display("FAIL std_latency: done at negedge %0d, expected 5", cyc); end
      n_checks++;
      if (ready_low != 4) begin n_fail++; $display("FAIL std_ready_low: %0d cycles, expected 4", ready_low); end
      n_checks++;
      if (busy_high != 4) begin n_fail++; $display("FAIL std_busy_high: %0d cycles, expected 4", busy_high); end
   endtask

   task automatic test_second_vector();
      int cyc;
      int ready_low;
      int busy_high;
      cyc       = -1;
      ready_low = 0;
      busy_high = 0;
      @(negedge clk);
      drive_block(16'h24EC, 16'h4AF5, 16'hD728);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done === 1'b1) begin
            cyc = c;
            break;
         end
         if (ready === 1'b0) ready_low++;
         if (busy === 1'b1) busy_high++;
      end
      n_checks++;
      if (cyc != 5) begin n_fail++; $display("FAIL vec2_latency: done at negedge %0d, expected 5", cyc); end
      n_checks++;
      if (ready_low != 4) begin n_fail++; $display("FAIL vec2_ready_low: %0d cycles, expected 4", ready_low); end
      n_checks++;
      if (busy_high != 4) begin n_fail++; $display("FAIL vec2_busy_high: %0d cycles, expected 4", busy_high); end
      @(negedge clk);
      n_checks++;
      if (plaintext !== 16'hD728) begin n_fail++; $display("FAIL vec2_hold: plaintext=%h, expected d728", plaintext); end
   endtask

   task automatic test_busy_reject();
      int base;
      int seen;
      base = done_cnt;
      @(negedge clk);
      drive_block(16'h0738, 16'hA73B, 16'h6F6B);
      @(negedge clk);             // KEY
      start = 1'b0;
      @(negedge clk);             // R1: pulse a competing request
      start      = 1'b1;
      ciphertext = 16'h24EC;
      key        = 16'h4AF5;
      @(negedge clk);             // R2
      start = 1'b0;
      repeat (12) @(negedge clk);
      seen = done_cnt - base;
      n_checks++;
      if (seen != 1) begin n_fail++; $display("FAIL busy_reject_dones: got %0d, expected 1", seen); end
      n_checks++;
      if (plaintext !== 16'h6F6B) begin n_fail++; $display("FAIL busy_reject_pt: plaintext=%h, expected 6f6b", plaintext); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int held_bad;
      cyc      = -1;
      held_bad = 0;
      @(negedge clk);
      drive_block(16'h24EC, 16'h4AF5, 16'hD728);   // set plaintext to something other than 6F6B
      run_to_done(cyc);
      @(negedge clk);
      drive_block(16'h0738, 16'hA73B, 16'h6F6B);
      run_to_done(cyc);
      n_checks++;
      if (cyc != 5) begin n_fail++; $display("FAIL b2b_first_latency: done at negedge %0d, expected 5", cyc); end
      // Present the second block during DONE of the first.
      drive_block(16'h24EC, 16'h4AF5, 16'hD728);
      cyc = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done === 1'b1) begin
            cyc = c;
            break;
         end
         if (plaintext !== 16'h6F6B) held_bad++;
      end
      n_checks++;
      if (cyc != 5) begin n_fail++; $display("FAIL b2b_second_latency: done at negedge %0d, expected 5", cyc); end
      n_checks++;
      if (held_bad != 0) begin n_fail++; $display("FAIL b2b_hold: %0d cycles without 6f6b, expected 0", held_bad); end
   endtask

   task automatic test_reset_mid_op();
      int cyc;
      @(negedge clk);
      drive_block(16'h0738, 16'hA73B, 16'h6F6B);
      @(negedge clk);             // KEY
      start = 1'b0;
      @(negedge clk);             // R1
      @(negedge clk);             // R2
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      n_checks++;
      if (plaintext !== 16'h0000) begin n_fail++; $display("FAIL midrst_plaintext: got %h, expected 0000", plaintext); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b, expected 0", done); end
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, expected 1", ready); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      drive_block(16'h24EC, 16'h4AF5, 16'hD728);
      run_to_done(cyc);
      n_checks++;
      if (cyc != 5) begin n_fail++; $display("FAIL midrst_after_latency: done at negedge %0d, expected 5", cyc); end
      @(negedge clk);
   endtask

   task automatic test_round_trip();
      int          cyc;
      logic [15:0] pt;
      logic [15:0] k;
      for (int i = 0; i < 1000; i++) begin
         pt = 16'($urandom_range(0, 65535));
         k  = 16'($urandom_range(0, 65535));
         @(negedge clk);
         drive_block(encrypt(pt, k), k, pt);
         run_to_done(cyc);
         if (cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL round_trip_timeout: vector %0d got no done, expected done", i);
         end
      end
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL round_trip_drain: %0d left in queue, expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_standard();
      test_second_vector();
      test_busy_reject();
      test_back_to_back();
      test_reset_mid_op();
      test_round_trip();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
